mipi_packetizer: RTL and testbench

MIPI_PACKETIZER -- requirements
Module: mipi_packetizer

---
 rtl/mipi_packetizer_pkg.sv | 42 ++++
 rtl/mipi_packetizer_ecc.sv | 30 +++
 rtl/mipi_packetizer.sv | 191 +++++++++++++++++++
 tb/tb_mipi_packetizer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mipi_packetizer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mipi_packetizer_pkg : CSI-2 data types, FSM encoding, CRC-16 constants   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mipi_packetizer_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HS_PREP = 3'd1;
  localparam state_t ST_HDR0    = 3'd2;
  localparam state_t ST_HDR1    = 3'd3;
  localparam state_t ST_PAYLOAD = 3'd4;
  localparam state_t ST_CRC     = 3'd5;
  localparam state_t ST_TRAIL   = 3'd6;

  typedef logic [1:0] kind_t;
  localparam kind_t KIND_FS   = 2'd0;
  localparam kind_t KIND_LINE = 2'd1;
  localparam kind_t KIND_FE   = 2'd2;

  localparam logic [15:0] CRC_SEED = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  // Bit-reversed polynomial for the LSB-first shift direction.
  localparam logic [15:0] CRC_POLY_REF = {<<{CRC_POLY}};

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REF;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_packetizer_ecc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mipi_ecc_gen : CSI-2 packet-header Hamming ECC over {WC, DI}             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mipi_ecc_gen (
  input  logic [23:0] i_data,
  output logic [7:0]  o_ecc
);

  // Each parity bit is the XOR of the header bits selected by its mask.
  localparam logic [23:0] C_MASK_P0 = 24'hF12CB7;
  localparam logic [23:0] C_MASK_P1 = 24'hF2555B;
  localparam logic [23:0] C_MASK_P2 = 24'h749A6D;
  localparam logic [23:0] C_MASK_P3 = 24'hB8E38E;
  localparam logic [23:0] C_MASK_P4 = 24'hDF03F0;
  localparam logic [23:0] C_MASK_P5 = 24'hEFFC00;

  always_comb begin
    o_ecc    = 8'h00;
    o_ecc[0] = ^(i_data & C_MASK_P0);
    o_ecc[1] = ^(i_data & C_MASK_P1);
    o_ecc[2] = ^(i_data & C_MASK_P2);
    o_ecc[3] = ^(i_data & C_MASK_P3);
    o_ecc[4] = ^(i_data & C_MASK_P4);
    o_ecc[5] = ^(i_data & C_MASK_P5);
  end

endmodule
`default_nettype wire

// File: rtl/mipi_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mipi_packetizer : CSI-2 short/long packet framer (FS, FE, line payload)  |
// | Optional payload CRC-16 word enabled by defining MIPI_PKT_CRC_EN.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mipi_packetizer
  import mipi_packetizer_pkg::*;
#(
  parameter int          Lane_Num        = 2,
  parameter int          Byte_w          = 8,
  parameter int          Lane_Width      = Lane_Num * Byte_w,
  parameter logic [5:0]  Data_Type       = DT_RAW10,
  parameter logic [1:0]  Virtual_Channel = 2'd0
) (
  input  logic                  I_CLK,
  input  logic                  I_Rst_n,
  input  logic                  I_Frame_Start,
  input  logic                  I_Frame_End,
  input  logic                  I_Line_Req,
  input  logic [15:0]           I_Word_Count,
  input  logic [Lane_Width-1:0] I_Pixel_Data,
  input  logic                  I_Pixel_Vaild,
  output logic                  O_Pixel_Ready,
  output logic                  O_Hs_En,
  output logic [Lane_Width-1:0] O_Mipi_Data,
  output logic                  O_Mipi_Vaild,
  output logic                  O_Busy,
  output logic                  O_Err
);

  state_t      r_state;
  state_t      w_state_nxt;
  kind_t       r_kind;
  kind_t       w_kind;
  logic [15:0] r_wc;
  logic [7:0]  r_di;
  logic [14:0] r_cnt;
  logic [15:0] r_frame;
  logic        r_err;
  logic        w_go;
  logic        w_reject;
  logic        w_bad_wc;
  logic        w_underflow;
  logic [5:0]  w_dt;
  logic [7:0]  w_ecc;
  logic [Lane_Width-1:0] w_pay_word;

  // Request arbitration: FS beats line beats FE, losers are silently dropped.
  always_comb begin
    w_bad_wc = I_Word_Count[0] || (I_Word_Count == 16'd0);
    w_go     = 1'b0;
    w_reject = 1'b0;
    w_kind   = KIND_FS;
    if (r_state == ST_IDLE) begin
      if (I_Frame_Start) begin
        w_go   = 1'b1;
        w_kind = KIND_FS;
      end else if (I_Line_Req) begin
        w_go     = !w_bad_wc;
        w_reject = w_bad_wc;
        w_kind   = KIND_LINE;
      end else if (I_Frame_End) begin
        w_go   = 1'b1;
        w_kind = KIND_FE;
      end
    end
  end

  always_comb begin
    case (w_kind)
      KIND_LINE: w_dt = Data_Type;
      KIND_FE:   w_dt = DT_FE;
      default:   w_dt = DT_FS;
    endcase
  end

  assign w_underflow = (r_state == ST_PAYLOAD) && !I_Pixel_Vaild;
  assign w_pay_word  = I_Pixel_Vaild ? I_Pixel_Data : '0;

  always_ff @(posedge I_CLK) begin
    if (!I_Rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_go) w_state_nxt = ST_HS_PREP;
      ST_HS_PREP: w_state_nxt = ST_HDR0;
      ST_HDR0:    w_state_nxt = ST_HDR1;
      ST_HDR1:    w_state_nxt = (r_kind == KIND_LINE) ? ST_PAYLOAD : ST_TRAIL;
      ST_PAYLOAD: begin
        if (r_cnt == 15'd1) begin
`ifdef MIPI_PKT_CRC_EN
          w_state_nxt = ST_CRC;
`else
          w_state_nxt = ST_TRAIL;
`endif
        end
      end
      ST_CRC:     w_state_nxt = ST_TRAIL;
      ST_TRAIL:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_Rst_n) begin
      r_kind  <= KIND_FS;
      r_wc    <= 16'd0;
      r_di    <= 8'd0;
      r_cnt   <= 15'd0;
      r_frame <= 16'd1;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject || w_underflow;
      if (w_go) begin
        r_kind <= w_kind;
        r_wc   <= (w_kind == KIND_LINE) ? I_Word_Count : r_frame;
        r_di   <= {Virtual_Channel, w_dt};
        r_cnt  <= I_Word_Count[15:1];
      end else if (r_state == ST_PAYLOAD) begin
        r_cnt <= r_cnt - 15'd1;
      end
      // Frame number 0 is reserved, so the counter skips it on wrap.
      if (r_state == ST_TRAIL && r_kind == KIND_FE)
        r_frame <= (r_frame == 16'hFFFF) ? 16'd1 : r_frame + 16'd1;
    end
  end

`ifdef MIPI_PKT_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;

  always_comb begin
    w_crc_nxt = r_crc;
    for (int b = 0; b < Lane_Num; b++)
      w_crc_nxt = crc16_byte(w_crc_nxt, w_pay_word[b*Byte_w +: 8]);
  end

  always_ff @(posedge I_CLK) begin
    if (!I_Rst_n)                    r_crc <= CRC_SEED;
    else if (w_go)                   r_crc <= CRC_SEED;
    else if (r_state == ST_PAYLOAD)  r_crc <= w_crc_nxt;
  end
`endif

  mipi_ecc_gen u_ecc (
    .i_data (({r_wc, r_di})),
    .o_ecc  (w_ecc)
  );

  always_comb begin
    O_Busy        = (r_state != ST_IDLE);
    O_Hs_En       = 1'b0;
    O_Mipi_Vaild  = 1'b0;
    O_Pixel_Ready = 1'b0;
    O_Mipi_Data   = '0;
    O_Err         = r_err;
    case (r_state)
      ST_HS_PREP: O_Hs_En = 1'b1;
      ST_HDR0: begin
        O_Hs_En      = 1'b1;
        O_Mipi_Vaild = 1'b1;
        O_Mipi_Data  = Lane_Width'({r_wc[7:0], r_di});
      end
      ST_HDR1: begin
        O_Hs_En      = 1'b1;
        O_Mipi_Vaild = 1'b1;
        O_Mipi_Data  = Lane_Width'({w_ecc, r_wc[15:8]});
      end
      ST_PAYLOAD: begin
        O_Hs_En       = 1'b1;
        O_Mipi_Vaild  = 1'b1;
        O_Pixel_Ready = 1'b1;
        O_Mipi_Data   = w_pay_word;
      end
`ifdef MIPI_PKT_CRC_EN
      ST_CRC: begin
        O_Hs_En      = 1'b1;
        O_Mipi_Vaild = 1'b1;
        O_Mipi_Data  = Lane_Width'(r_crc);
      end
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mipi_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mipi_packetizer : directed table-driven bench for mipi_packetizer     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mipi_packetizer;

`ifdef MIPI_PKT_CRC_EN
  localparam int C_CRCW = 1;
`else
  localparam int C_CRCW = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs, fe, line_req, pix_vld;
  logic [15:0] wc, pix;
  logic        ready, hs, mvld, busy, err;
  logic [15:0] mdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mipi_packetizer dut (
    .I_CLK         (clk),
    .I_Rst_n       (rst_n),
    .I_Frame_Start (fs),
    .I_Frame_End   (fe),
    .I_Line_Req    (line_req),
    .I_Word_Count  (wc),
    .I_Pixel_Data  (pix),
    .I_Pixel_Vaild (pix_vld),
    .O_Pixel_Ready (ready),
    .O_Hs_En       (hs),
    .O_Mipi_Data   (mdata),
    .O_Mipi_Vaild  (mvld),
    .O_Busy        (busy),
    .O_Err         (err)
  );

  typedef struct {
    logic        fs, line, fe;
    logic [15:0] wc;
    int          gap;
    logic [15:0] base;
    logic        step;
    int          exp_n;
    logic [15:0] exp_h0, exp_h1;
    int          exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC as the serial LFSR: taps at bits 15, 10 and 3 after the shift.
  function automatic logic [15:0] ref_crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c = {fb, c[15:1]};
      c[10] = c[10] ^ fb;
      c[3]  = c[3] ^ fb;
    end
    return c;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic [15:0] words[$];
    int nerr, ntrail, trail_pos, first_v, pcnt, nbad_pay, npay;
    logic busy_seen, done, leak;
    logic [2:0] prep;
    logic [15:0] e, crc;
    string n;
    n = $sformatf("v%0d", idx);
    nerr = 0; ntrail = 0; trail_pos = -1; first_v = -1; pcnt = 0;
    busy_seen = 0; done = 0; leak = 0; prep = 3'b111;
    @(posedge clk); #1;
    fs = v.fs; line_req = v.line; fe = v.fe; wc = v.wc;
    @(posedge clk); #1;
    fs = 0; line_req = 0; fe = 0;
    for (int c = 0; c < 3000; c++) begin
      pix_vld = (pcnt != v.gap);
      pix = v.base + (v.step ? 16'(pcnt) : 16'd0);
      @(negedge clk);
      if (c == 0) prep = {busy, hs, mvld};
      if (err) nerr++;
      if (busy) busy_seen = 1;
      if (!mvld && mdata != 16'd0) leak = 1;
      if (mvld) begin
        if (first_v < 0) first_v = c;
        words.push_back(mdata);
      end
      if (busy && !mvld && !hs) begin
        ntrail++;
        trail_pos = words.size();
      end
      if (ready) pcnt++;
      if (!busy && c >= 1) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    pix_vld = 1;
    chk({n, "_done"}, 32'(done), 32'd1);
    chk({n, "_prep"}, 32'(prep), (v.exp_n > 0) ? 32'h6 : 32'h0);
    chk({n, "_nwords"}, words.size(), v.exp_n);
    chk({n, "_err"}, nerr, v.exp_err);
    chk({n, "_leak"}, 32'(leak), 32'd0);
    if (v.exp_n > 0 && words.size() >= 2) begin
      chk({n, "_hdr0"}, words[0], v.exp_h0);
      chk({n, "_hdr1"}, words[1], v.exp_h1);
      chk({n, "_hdr0_cycle"}, first_v, 1);
      chk({n, "_trail_cnt"}, ntrail, 1);
      chk({n, "_trail_pos"}, trail_pos, words.size());
      npay = (!v.fs && v.line) ? int'(v.wc) / 2 : 0;
      nbad_pay = 0;
      crc = 16'hFFFF;
      for (int j = 0; j < npay; j++) begin
        e = (j == v.gap) ? 16'd0 : v.base + (v.step ? 16'(j) : 16'd0);
        crc = ref_crc_byte(ref_crc_byte(crc, e[7:0]), e[15:8]);
        if (2 + j >= words.size() || words[2+j] !== e) nbad_pay++;
      end
      chk({n, "_payload_bad"}, nbad_pay, 0);
      if (C_CRCW == 1 && npay > 0 && words.size() == 3 + npay)
        chk({n, "_crc"}, words[2+npay], crc);
    end else begin
      chk({n, "_busy_seen"}, 32'(busy_seen), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p5;
    logic got5;
    //        fs line fe  wc     gap base    step exp_n          h0        h1        err
    tbl[0]  = '{1, 0, 0, 16'd0,    -1, 16'h0000, 0, 2,            16'h0100, 16'h1A00, 0};
    tbl[1]  = '{0, 1, 0, 16'd2400, -1, 16'h1000, 1, 2+1200+C_CRCW, 16'h602B, 16'h1D09, 0};
    tbl[2]  = '{0, 1, 0, 16'd7,    -1, 16'h0000, 0, 0,            16'h0000, 16'h0000, 1};
    tbl[3]  = '{0, 1, 0, 16'd0,    -1, 16'h0000, 0, 0,            16'h0000, 16'h0000, 1};
    tbl[4]  = '{0, 0, 1, 16'd0,    -1, 16'h0000, 0, 2,            16'h0101, 16'h1D00, 0};
    tbl[5]  = '{1, 0, 0, 16'd0,    -1, 16'h0000, 0, 2,            16'h0200, 16'h1C00, 0};
    tbl[6]  = '{1, 0, 1, 16'd0,    -1, 16'h0000, 0, 2,            16'h0200, 16'h1C00, 0};
    tbl[7]  = '{0, 1, 0, 16'd4,     1, 16'hA5C3, 1, 4+C_CRCW,     16'h042B, 16'h3400, 1};
    tbl[8]  = '{1, 1, 0, 16'd4,    -1, 16'h0000, 0, 2,            16'h0200, 16'h1C00, 0};
    tbl[9]  = '{0, 0, 1, 16'd0,    -1, 16'h0000, 0, 2,            16'h0201, 16'h1B00, 0};
    tbl[10] = '{1, 0, 0, 16'd0,    -1, 16'h0000, 0, 2,            16'h0300, 16'h0600, 0};
    tbl[11] = '{0, 1, 0, 16'd4,    -1, 16'h0000, 0, 4+C_CRCW,     16'h042B, 16'h3400, 0};

    rst_n = 0; fs = 0; fe = 0; line_req = 0; wc = 0; pix = 0; pix_vld = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {15'd0, busy, hs, mvld, ready, err, 16'(mdata)}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    // Reset while the 5th payload word of a long line is on the bus.
    @(posedge clk); #1;
    line_req = 1; wc = 16'd2400; pix_vld = 1;
    @(posedge clk); #1;
    line_req = 0;
    p5 = 0; got5 = 0;
    for (int c = 0; c < 40; c++) begin
      pix = 16'h5000 + 16'(p5);
      @(negedge clk);
      if (ready) begin
        p5++;
        if (p5 == 5) begin
          got5 = 1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    chk("rst_reach_word5", 32'(got5), 32'd1);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_outputs", {15'd0, busy, hs, mvld, ready, err, 16'(mdata)}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_stays_idle", {29'd0, busy, hs, mvld}, 32'd0);
    run_vec(12, tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
